// File: rtl/vend_pkg.sv
// Shared vending definitions: keypad control codes, entry-state encoding and
// the decimal composition helper used when a two-digit selection is submitted.
package vend_pkg;

  localparam logic [3:0] KEY_CLEAR = 4'd10;
  localparam logic [3:0] KEY_ENTER = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ONE  = 2'd1,
    ST_TWO  = 2'd2,
    ST_HOLD = 2'd3
  } entry_state_e;

  // tens*10 + units using shifts only; the result never exceeds 99.
  function automatic logic [6:0] item_value(input logic [3:0] t, input logic [3:0] u);
    logic [6:0] t7;
    t7 = {3'b000, t};
    return (t7 << 3) + (t7 << 1) + {3'b000, u};
  endfunction

endpackage

// File: rtl/key_qualify.sv
// Turns the scanner's level strobe into a single key event per press:
// rising-edge detect plus a holdoff window after each accepted key.
module key_qualify #(
  parameter int HOLDOFF_CYCLES = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       valid,
  input  logic [3:0] code,
  output logic       key_stb,
  output logic [3:0] key_code
);

  localparam int HW = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;

  logic          valid_q, valid_d;
  logic [HW-1:0] hold_q, hold_d;

  // The strobe is decoded from registered history so the FSM can act on the
  // very edge that samples the new press.
  always_comb begin
    valid_d  = valid;
    key_stb  = valid & ~valid_q & (hold_q == '0);
    key_code = code;
    hold_d   = hold_q;
    if (key_stb) begin
      hold_d = HW'(HOLDOFF_CYCLES);
    end else if (hold_q != '0) begin
      hold_d = hold_q - HW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      valid_q <= valid_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: rtl/keypad_entry.sv
// Keypad selection entry: builds a 0-99 item number from digit keys and
// presents it downstream on a valid/ready handshake, with inactivity timeout.
module keypad_entry
  import vend_pkg::*;
#(
  parameter int HOLDOFF_CYCLES = 1000,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] code,
  input  logic       valid,
  input  logic       item_ready,
  output logic [6:0] item,
  output logic       item_valid,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic [1:0] count,
  output logic       err,
  output logic       timeout
);

  localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic       key_stb;
  logic [3:0] key_code;
  logic       is_digit;

  entry_state_e  state_q, state_d;
  logic [3:0]    tens_q, tens_d, units_q, units_d;
  logic [6:0]    item_q, item_d;
  logic [1:0]    count_q, count_d;
  logic          err_q, err_d, timeout_q, timeout_d;
  logic [TW-1:0] tmo_q, tmo_d;

  key_qualify #(.HOLDOFF_CYCLES(HOLDOFF_CYCLES)) u_qualify (
    .clock    (clock),
    .reset    (reset),
    .valid    (valid),
    .code     (code),
    .key_stb  (key_stb),
    .key_code (key_code)
  );

  assign is_digit = (key_code <= 4'd9);

  // The idle counter defaults to zero, so any accepted key or state entry restarts it.
  always_comb begin
    state_d   = state_q;
    tens_d    = tens_q;
    units_d   = units_q;
    item_d    = item_q;
    count_d   = count_q;
    err_d     = 1'b0;
    timeout_d = 1'b0;
    tmo_d     = '0;
    case (state_q)
      ST_IDLE: begin
        if (key_stb) begin
          if (is_digit) begin
            tens_d  = key_code;
            count_d = 2'd1;
            state_d = ST_ONE;
          end else if (key_code != KEY_CLEAR) begin
            err_d = 1'b1;
          end
        end
      end
      ST_ONE: begin
        if (key_stb) begin
          if (is_digit) begin
            units_d = key_code;
            count_d = 2'd2;
            state_d = ST_TWO;
          end else if (key_code == KEY_CLEAR) begin
            tens_d  = 4'd0;
            count_d = 2'd0;
            state_d = ST_IDLE;
          end else if (key_code == KEY_ENTER) begin
            item_d  = {3'b000, tens_q};
            state_d = ST_HOLD;
          end else begin
            err_d = 1'b1;
          end
        end else if (tmo_q == TMO_LAST) begin
          tens_d    = 4'd0;
          units_d   = 4'd0;
          count_d   = 2'd0;
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_TWO: begin
        if (key_stb) begin
          if (key_code == KEY_CLEAR) begin
            tens_d  = 4'd0;
            units_d = 4'd0;
            count_d = 2'd0;
            state_d = ST_IDLE;
          end else if (key_code == KEY_ENTER) begin
            item_d  = item_value(tens_q, units_q);
            state_d = ST_HOLD;
          end else begin
            err_d = 1'b1;
          end
        end else if (tmo_q == TMO_LAST) begin
          tens_d    = 4'd0;
          units_d   = 4'd0;
          count_d   = 2'd0;
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_HOLD: begin
        // Keys never disturb a pending item, even one completing this cycle.
        err_d = key_stb;
        if (item_ready) begin
          item_d  = 7'd0;
          tens_d  = 4'd0;
          units_d = 4'd0;
          count_d = 2'd0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      tens_q    <= 4'd0;
      units_q   <= 4'd0;
      item_q    <= 7'd0;
      count_q   <= 2'd0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      tens_q    <= tens_d;
      units_q   <= units_d;
      item_q    <= item_d;
      count_q   <= count_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
      tmo_q     <= tmo_d;
    end
  end

  assign item       = item_q;
  assign item_valid = (state_q == ST_HOLD);
  assign tens       = tens_q;
  assign units      = units_q;
  assign count      = count_q;
  assign err        = err_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Scenario bench for keypad_entry with HOLDOFF_CYCLES=4, TIMEOUT_CYCLES=20;
// submitted items are checked against a queue of expected selections.
module tb_keypad_entry;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] code = 4'd0;
  logic       valid = 1'b0;
  logic       item_ready = 1'b0;
  logic [6:0] item;
  logic       item_valid;
  logic [3:0] tens, units;
  logic [1:0] count;
  logic       err, timeout;

  int checks = 0;
  int errors = 0;
  logic [6:0] exp_q[$];
  logic [6:0] exp_v;

  keypad_entry #(.HOLDOFF_CYCLES(4), .TIMEOUT_CYCLES(20)) dut (
    .clock      (clock),
    .reset      (reset),
    .code       (code),
    .valid      (valid),
    .item_ready (item_ready),
    .item       (item),
    .item_valid (item_valid),
    .tens       (tens),
    .units      (units),
    .count      (count),
    .err        (err),
    .timeout    (timeout)
  );

  always #5 clock = ~clock;

  // Inputs change 1ns after posedge, so the falling edge sees a stable handshake.
  always @(negedge clock) begin
    if (!reset && item_valid && item_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL item_unexpected: got %0d required none", item);
      end else begin
        exp_v = exp_q.pop_front();
        if (item !== exp_v) begin
          errors++;
          $display("FAIL item_value: got %0d required %0d", item, exp_v);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // One-cycle press; returns 1ns after the accepting edge.
  task automatic press(input logic [3:0] c);
    code  = c;
    valid = 1'b1;
    tick();
    valid = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({item, item_valid, tens, units, count, err, timeout} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", {item, item_valid, tens, units, count, err, timeout});
    end
    idle(2);
    checks++;
    if ({item_valid, count} !== 3'd0) begin
      errors++;
      $display("FAIL reset_held: got %h required 0", {item_valid, count});
    end
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_two_digit();
    item_ready = 1'b1;
    press(4'd4);
    checks++;
    if (tens !== 4'd4 || count !== 2'd1) begin
      errors++;
      $display("FAIL two_first: got tens=%0d count=%0d required 4 1", tens, count);
    end
    idle(5);
    press(4'd2);
    checks++;
    if (units !== 4'd2 || count !== 2'd2) begin
      errors++;
      $display("FAIL two_second: got units=%0d count=%0d required 2 2", units, count);
    end
    idle(5);
    exp_q.push_back(7'd42);
    press(4'd11);
    checks++;
    if (item_valid !== 1'b1 || item !== 7'd42) begin
      errors++;
      $display("FAIL two_enter: got valid=%0d item=%0d required 1 42", item_valid, item);
    end
    tick();
    checks++;
    if (item_valid !== 1'b0 || count !== 2'd0 || item !== 7'd0) begin
      errors++;
      $display("FAIL two_done: got valid=%0d count=%0d item=%0d required 0 0 0", item_valid, count, item);
    end
    idle(5);
  endtask

  task automatic test_stall();
    item_ready = 1'b0;
    press(4'd7);
    idle(5);
    exp_q.push_back(7'd7);
    press(4'd11);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (item_valid !== 1'b1 || item !== 7'd7) begin
        errors++;
        $display("FAIL stall_hold cycle %0d: got valid=%0d item=%0d required 1 7", i, item_valid, item);
      end
      if (i < 9) tick();
    end
    item_ready = 1'b1;
    tick();
    checks++;
    if (item_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_drop: got valid=%0d required 0", item_valid);
    end
    idle(5);
  endtask

  task automatic test_bounce();
    code = 4'd5;
    for (int i = 0; i < 3; i++) begin
      valid = 1'b1;
      tick();
      valid = 1'b0;
      checks++;
      if (err !== 1'b0) begin
        errors++;
        $display("FAIL bounce_err edge %0d: got %0d required 0", i, err);
      end
      if (i < 2) tick();
    end
    tick();
    checks++;
    if (tens !== 4'd5 || count !== 2'd1) begin
      errors++;
      $display("FAIL bounce_count: got tens=%0d count=%0d required 5 1", tens, count);
    end
    idle(5);
    press(4'd10);
    checks++;
    if (count !== 2'd0 || tens !== 4'd0 || err !== 1'b0) begin
      errors++;
      $display("FAIL bounce_clear: got count=%0d tens=%0d err=%0d required 0 0 0", count, tens, err);
    end
    idle(5);
  endtask

  task automatic test_errors();
    press(4'd11);
    checks++;
    if (err !== 1'b1 || count !== 2'd0 || item_valid !== 1'b0) begin
      errors++;
      $display("FAIL err_enter_idle: got err=%0d count=%0d valid=%0d required 1 0 0", err, count, item_valid);
    end
    tick();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_pulse_width: got %0d required 0", err);
    end
    idle(5);
    press(4'd9);
    idle(5);
    press(4'd9);
    idle(5);
    press(4'd5);
    checks++;
    if (err !== 1'b1 || count !== 2'd2 || units !== 4'd9) begin
      errors++;
      $display("FAIL err_third_digit: got err=%0d count=%0d units=%0d required 1 2 9", err, count, units);
    end
    idle(5);
    item_ready = 1'b0;
    exp_q.push_back(7'd99);
    press(4'd11);
    idle(5);
    press(4'd10);
    checks++;
    if (err !== 1'b1 || item_valid !== 1'b1 || item !== 7'd99) begin
      errors++;
      $display("FAIL err_clear_hold: got err=%0d valid=%0d item=%0d required 1 1 99", err, item_valid, item);
    end
    idle(5);
    item_ready = 1'b1;
    code  = 4'd3;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    checks++;
    if (err !== 1'b1 || item_valid !== 1'b0 || count !== 2'd0 || tens !== 4'd0) begin
      errors++;
      $display("FAIL err_key_on_transfer: got err=%0d valid=%0d count=%0d tens=%0d required 1 0 0 0",
               err, item_valid, count, tens);
    end
    idle(5);
    press(4'd13);
    checks++;
    if (err !== 1'b1 || count !== 2'd0) begin
      errors++;
      $display("FAIL err_code13: got err=%0d count=%0d required 1 0", err, count);
    end
    idle(5);
  endtask

  task automatic test_timeout();
    press(4'd3);
    idle(19);
    checks++;
    if (timeout !== 1'b0 || count !== 2'd1) begin
      errors++;
      $display("FAIL tmo_early: got timeout=%0d count=%0d required 0 1", timeout, count);
    end
    tick();
    checks++;
    if (timeout !== 1'b1 || count !== 2'd0 || tens !== 4'd0) begin
      errors++;
      $display("FAIL tmo_fire: got timeout=%0d count=%0d tens=%0d required 1 0 0", timeout, count, tens);
    end
    tick();
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL tmo_pulse_width: got %0d required 0", timeout);
    end
    idle(5);
    press(4'd3);
    idle(19);
    press(4'd6);
    checks++;
    if (timeout !== 1'b0 || count !== 2'd2 || units !== 4'd6 || tens !== 4'd3) begin
      errors++;
      $display("FAIL tmo_key_wins: got timeout=%0d count=%0d tens=%0d units=%0d required 0 2 3 6",
               timeout, count, tens, units);
    end
    tick();
    checks++;
    if (timeout !== 1'b0 || count !== 2'd2) begin
      errors++;
      $display("FAIL tmo_key_wins_after: got timeout=%0d count=%0d required 0 2", timeout, count);
    end
    idle(5);
    press(4'd10);
    idle(5);
  endtask

  task automatic test_reset_hold();
    item_ready = 1'b0;
    press(4'd8);
    idle(5);
    press(4'd11);
    checks++;
    if (item_valid !== 1'b1 || item !== 7'd8) begin
      errors++;
      $display("FAIL rst_hold_setup: got valid=%0d item=%0d required 1 8", item_valid, item);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({item, item_valid, tens, units, count, err, timeout} !== 21'd0) begin
      errors++;
      $display("FAIL rst_hold_async: got %h required 0", {item, item_valid, tens, units, count, err, timeout});
    end
    tick();
    reset = 1'b0;
    idle(2);
  endtask

  initial begin
    test_reset();
    test_two_digit();
    test_stall();
    test_bounce();
    test_errors();
    test_timeout();
    test_reset_hold();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
